mem_arbiter: RTL and testbench

Two-port arbiter sharing a single mem_in_type/mem_out_type memory (the on-chip ram) between the instruction-fetch port and the data port.
- Captures single-cycle request pulses and grants round-robin.
- Holds one transaction in flight at a time.
- Routes the response back to the owner.
- Returns an error if the memory fails to respond within a bounded number of cycles.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter: instruction-fetch and data ports share one memory.
// One downstream transaction in flight; responses routed to owner, bounded by a timeout.
package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
  } mem_out_type;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned timeout_cycles = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  ram_in,
  input  mem_out_type ram_out
);

  localparam int unsigned CW = $clog2(timeout_cycles);
  localparam logic [CW-1:0] TMO_LAST = CW'(timeout_cycles - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  typedef enum logic {P_INST, P_DATA} port_e;

  state_e      state_q, state_d;
  port_e       owner_q, owner_d;
  port_e       last_q, last_d;
  logic        ipend_q, ipend_d;
  logic        dpend_q, dpend_d;
  mem_in_type  ireq_q, ireq_d;
  mem_in_type  dreq_q, dreq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_in_type  ram_in_q, ram_in_d;
  mem_out_type imem_out_q, imem_out_d;
  mem_out_type dmem_out_q, dmem_out_d;

  logic        i_busy, d_busy, i_acc, d_acc, i_cand, d_cand;
  logic        ready_hit, tmo, done, can_arb;
  port_e       gnt;
  mem_in_type  i_slot, d_slot;
  mem_out_type resp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= P_INST;
      last_q     <= P_DATA;
      ipend_q    <= 1'b0;
      dpend_q    <= 1'b0;
      ireq_q     <= '0;
      dreq_q     <= '0;
      cnt_q      <= '0;
      ram_in_q   <= '0;
      imem_out_q <= '0;
      dmem_out_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      ipend_q    <= ipend_d;
      dpend_q    <= dpend_d;
      ireq_q     <= ireq_d;
      dreq_q     <= dreq_d;
      cnt_q      <= cnt_d;
      ram_in_q   <= ram_in_d;
      imem_out_q <= imem_out_d;
      dmem_out_q <= dmem_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    ipend_d    = ipend_q;
    dpend_d    = dpend_q;
    ireq_d     = ireq_q;
    dreq_d     = dreq_q;
    cnt_d      = cnt_q;
    ram_in_d   = ram_in_q;
    ram_in_d.mem_valid = 1'b0;
    imem_out_d = '0;
    dmem_out_d = '0;
    gnt        = P_INST;
    resp       = '0;

    // A port is outstanding while pending or while its request is in flight.
    i_busy    = (state_q == S_BUSY) && (owner_q == P_INST);
    d_busy    = (state_q == S_BUSY) && (owner_q == P_DATA);
    i_acc     = imem_in.mem_valid && !ipend_q && !i_busy;
    d_acc     = dmem_in.mem_valid && !dpend_q && !d_busy;
    ready_hit = (state_q == S_BUSY) && ram_out.mem_ready;
    tmo       = (state_q == S_BUSY) && !ram_out.mem_ready && (cnt_q == TMO_LAST);
    done      = ready_hit || tmo;
    can_arb   = (state_q == S_IDLE) || done;
    i_cand    = ipend_q || i_acc;
    d_cand    = dpend_q || d_acc;
    i_slot    = ipend_q ? ireq_q : imem_in;
    d_slot    = dpend_q ? dreq_q : dmem_in;

    if (state_q == S_BUSY) begin
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        if (ready_hit) begin
          resp = ram_out;
        end else begin
          resp.mem_rdata = '0;
          resp.mem_error = 1'b1;
          resp.mem_ready = 1'b1;
        end
        if (owner_q == P_INST) imem_out_d = resp;
        else                   dmem_out_d = resp;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end

    if (i_acc) begin
      ipend_d = 1'b1;
      ireq_d  = imem_in;
    end
    if (d_acc) begin
      dpend_d = 1'b1;
      dreq_d  = dmem_in;
    end

    // Arbitration also runs on the completing edge so grants can go back-to-back.
    if (can_arb && (i_cand || d_cand)) begin
      if (i_cand && d_cand) begin
        gnt    = (last_q == P_INST) ? P_DATA : P_INST;
        last_d = gnt;
      end else begin
        gnt = i_cand ? P_INST : P_DATA;
      end
      if (gnt == P_INST) begin
        ram_in_d = i_slot;
        ipend_d  = 1'b0;
      end else begin
        ram_in_d = d_slot;
        dpend_d  = 1'b0;
      end
      ram_in_d.mem_valid = 1'b1;
      owner_d = gnt;
      state_d = S_BUSY;
      cnt_d   = '0;
    end
  end

  assign ram_in   = ram_in_q;
  assign imem_out = imem_out_q;
  assign dmem_out = dmem_out_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected downstream requests
// and upstream responses; a monitor pops and compares whenever the DUT presents one.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned TMO = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
    int unsigned c;
  } ram_exp_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int unsigned c;
  } rsp_exp_t;

  logic        clock;
  logic        reset;
  mem_in_type  imem_in, dmem_in, ram_in;
  mem_out_type imem_out, dmem_out, ram_out;

  ram_exp_t exp_ram[$];
  rsp_exp_t exp_i[$];
  rsp_exp_t exp_d[$];

  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  logic fin = 1'b0;
  event rst_chk_ev;

  mem_arbiter #(.timeout_cycles(TMO)) dut (
    .clock   (clock),
    .reset   (reset),
    .imem_in (imem_in),
    .imem_out(imem_out),
    .dmem_in (dmem_in),
    .dmem_out(dmem_out),
    .ram_in  (ram_in),
    .ram_out (ram_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic nxt();
    @(posedge clock);
    #1;
    imem_in.mem_valid = 1'b0;
    dmem_in.mem_valid = 1'b0;
    ram_out = '0;
  endtask

  task automatic req_i(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    imem_in.mem_valid = 1'b1;
    imem_in.mem_addr  = a;
    imem_in.mem_wdata = w;
    imem_in.mem_wstrb = s;
  endtask

  task automatic req_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = a;
    dmem_in.mem_wdata = w;
    dmem_in.mem_wstrb = s;
  endtask

  task automatic rsp(input logic [31:0] d, input logic e);
    ram_out.mem_rdata = d;
    ram_out.mem_error = e;
    ram_out.mem_ready = 1'b1;
  endtask

  task automatic push_ram(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                          input int unsigned c);
    ram_exp_t x;
    x.a = a; x.w = w; x.s = s; x.c = c;
    exp_ram.push_back(x);
  endtask

  task automatic push_i(input logic [31:0] d, input logic e, input int unsigned c);
    rsp_exp_t x;
    x.d = d; x.e = e; x.c = c;
    exp_i.push_back(x);
  endtask

  task automatic push_d(input logic [31:0] d, input logic e, input int unsigned c);
    rsp_exp_t x;
    x.d = d; x.e = e; x.c = c;
    exp_d.push_back(x);
  endtask

  // Stimulus
  initial begin
    int unsigned t;
    imem_in = '0;
    dmem_in = '0;
    ram_out = '0;
    reset   = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Single fetch
    nxt(); t = cyc;
    req_i(32'h100, 32'h0, 4'h0);
    push_ram(32'h100, 32'h0, 4'h0, t + 1);
    repeat (5) nxt();
    rsp(32'hDEADBEEF, 1'b0);
    push_i(32'hDEADBEEF, 1'b0, cyc + 1);
    repeat (3) nxt();

    // Simultaneous requests: imem first, dmem granted back-to-back
    nxt(); t = cyc;
    req_i(32'h0, 32'h0, 4'h0);
    req_d(32'h40, 32'h0, 4'h0);
    push_ram(32'h0, 32'h0, 4'h0, t + 1);
    repeat (3) nxt();
    rsp(32'h1111_0000, 1'b0);
    push_i(32'h1111_0000, 1'b0, cyc + 1);
    push_ram(32'h40, 32'h0, 4'h0, cyc + 1);
    repeat (2) nxt();
    rsp(32'h2222_0000, 1'b0);
    push_d(32'h2222_0000, 1'b0, cyc + 1);
    repeat (2) nxt();

    // Simultaneous again: dmem first
    nxt(); t = cyc;
    req_i(32'h4, 32'h0, 4'h0);
    req_d(32'h44, 32'h0, 4'h0);
    push_ram(32'h44, 32'h0, 4'h0, t + 1);
    repeat (3) nxt();
    rsp(32'h3333_0000, 1'b0);
    push_d(32'h3333_0000, 1'b0, cyc + 1);
    push_ram(32'h4, 32'h0, 4'h0, cyc + 1);
    repeat (2) nxt();
    rsp(32'h4444_0000, 1'b0);
    push_i(32'h4444_0000, 1'b0, cyc + 1);
    repeat (2) nxt();

    // Write routing
    nxt();
    req_d(32'h200, 32'h11223344, 4'b0101);
    push_ram(32'h200, 32'h11223344, 4'b0101, cyc + 1);
    repeat (2) nxt();
    rsp(32'h0, 1'b0);
    push_d(32'h0, 1'b0, cyc + 1);
    repeat (2) nxt();

    // Timeout, then stale ready in IDLE
    nxt(); t = cyc;
    req_d(32'h300, 32'h0, 4'h0);
    push_ram(32'h300, 32'h0, 4'h0, t + 1);
    push_d(32'h0, 1'b1, t + TMO + 1);
    repeat (TMO + 2) nxt();
    rsp(32'h5555_5555, 1'b0);
    repeat (3) nxt();

    // Ready on the last counter cycle wins over timeout
    nxt(); t = cyc;
    req_d(32'h304, 32'h0, 4'h0);
    push_ram(32'h304, 32'h0, 4'h0, t + 1);
    repeat (TMO) nxt();
    rsp(32'hCAFEF00D, 1'b0);
    push_d(32'hCAFEF00D, 1'b0, cyc + 1);
    repeat (3) nxt();

    // Second imem valid while in flight is dropped; error forwarded
    nxt(); t = cyc;
    req_i(32'h400, 32'h0, 4'h0);
    push_ram(32'h400, 32'h0, 4'h0, t + 1);
    repeat (2) nxt();
    req_i(32'h404, 32'h0, 4'h0);
    repeat (2) nxt();
    rsp(32'hBAD0BAD0, 1'b1);
    push_i(32'hBAD0BAD0, 1'b1, cyc + 1);
    repeat (4) nxt();

    // Reset while busy with dmem pending
    nxt();
    req_i(32'h500, 32'hA5A5A5A5, 4'hF);
    push_ram(32'h500, 32'hA5A5A5A5, 4'hF, cyc + 1);
    nxt();
    req_d(32'h504, 32'h0, 4'h0);
    nxt();
    #2 reset = 1'b0;
    #1 -> rst_chk_ev;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) nxt();
    rsp(32'h7777_7777, 1'b0);
    repeat (5) nxt();

    fin = 1'b1;
  end

  // Monitor / scoreboard
  always begin
    ram_exp_t er;
    rsp_exp_t ep;
    @(negedge clock or rst_chk_ev);
    if (!reset) begin
      total++;
      if (imem_out !== '0 || dmem_out !== '0 || ram_in !== '0) begin
        bad++;
        $display("FAIL reset_state: imem_out=%h dmem_out=%h ram_in=%h, want all 0",
                 imem_out, dmem_out, ram_in);
      end
    end else begin
      if (ram_in.mem_valid) begin
        total++;
        if (exp_ram.size() == 0) begin
          bad++;
          $display("FAIL ram_req: unexpected request addr=%h at cyc %0d, want none",
                   ram_in.mem_addr, cyc);
        end else begin
          er = exp_ram.pop_front();
          if (ram_in.mem_addr !== er.a || ram_in.mem_wdata !== er.w ||
              ram_in.mem_wstrb !== er.s || cyc != er.c) begin
            bad++;
            $display("FAIL ram_req: got addr=%h wdata=%h wstrb=%b cyc=%0d, want addr=%h wdata=%h wstrb=%b cyc=%0d",
                     ram_in.mem_addr, ram_in.mem_wdata, ram_in.mem_wstrb, cyc,
                     er.a, er.w, er.s, er.c);
          end
        end
      end
      if (imem_out.mem_ready) begin
        total++;
        if (exp_i.size() == 0) begin
          bad++;
          $display("FAIL imem_rsp: unexpected rdata=%h err=%b at cyc %0d, want none",
                   imem_out.mem_rdata, imem_out.mem_error, cyc);
        end else begin
          ep = exp_i.pop_front();
          if (imem_out.mem_rdata !== ep.d || imem_out.mem_error !== ep.e || cyc != ep.c) begin
            bad++;
            $display("FAIL imem_rsp: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                     imem_out.mem_rdata, imem_out.mem_error, cyc, ep.d, ep.e, ep.c);
          end
        end
      end
      if (dmem_out.mem_ready) begin
        total++;
        if (exp_d.size() == 0) begin
          bad++;
          $display("FAIL dmem_rsp: unexpected rdata=%h err=%b at cyc %0d, want none",
                   dmem_out.mem_rdata, dmem_out.mem_error, cyc);
        end else begin
          ep = exp_d.pop_front();
          if (dmem_out.mem_rdata !== ep.d || dmem_out.mem_error !== ep.e || cyc != ep.c) begin
            bad++;
            $display("FAIL dmem_rsp: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                     dmem_out.mem_rdata, dmem_out.mem_error, cyc, ep.d, ep.e, ep.c);
          end
        end
      end
      total++;
      if ((!imem_out.mem_ready && imem_out !== '0) || (!dmem_out.mem_ready && dmem_out !== '0)) begin
        bad++;
        $display("FAIL quiet_out: imem_out=%h dmem_out=%h at cyc %0d, want 0 when not ready",
                 imem_out, dmem_out, cyc);
      end
    end

    if (fin) begin
      total++;
      if (exp_ram.size() != 0) begin
        bad++;
        $display("FAIL ram_req_missing: %0d outstanding, want 0", exp_ram.size());
      end
      total++;
      if (exp_i.size() != 0) begin
        bad++;
        $display("FAIL imem_rsp_missing: %0d outstanding, want 0", exp_i.size());
      end
      total++;
      if (exp_d.size() != 0) begin
        bad++;
        $display("FAIL dmem_rsp_missing: %0d outstanding, want 0", exp_d.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end

    if (cyc > 5000) begin
      total++;
      bad++;
      $display("FAIL watchdog: cyc=%0d, want completion before 5000", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule
